// File: rtl/i2s_pkg.sv
// Shared types and defaults for the I2S receive controller.
// Channel constants match the ws_out level of each slot.
package i2s_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2,
        ST_STOP   = 2'd3
    } i2s_state_e;

    localparam int DEF_SLOT_BITS   = 32;
    localparam int DEF_SAMPLE_BITS = 24;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_sck_div.sv
// Bit-clock divider: toggles sck every HALF_DIV enabled cycles and emits
// registered rise/fall strobes in the same cycle the new sck level appears.
module i2s_sck_div #(
    parameter int HALF_DIV = 4
) (
    input  logic clk_in,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic sck,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_DIV - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             sck_r;
    logic             rise_r;
    logic             fall_r;

    // Half-period counter, sck level and edge strobes.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            cnt_r  <= {CNT_W{1'b0}};
            sck_r  <= 1'b0;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else if (clr || !en) begin
            cnt_r  <= {CNT_W{1'b0}};
            sck_r  <= 1'b0;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else if (cnt_r == CNT_LAST) begin
            cnt_r  <= {CNT_W{1'b0}};
            sck_r  <= ~sck_r;
            rise_r <= ~sck_r;
            fall_r <= sck_r;
        end else begin
            cnt_r  <= cnt_r + CNT_W'(1'b1);
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end
    end

    assign sck  = sck_r;
    assign rise = rise_r;
    assign fall = fall_r;

endmodule

// File: rtl/i2s_rx_ctrl.sv
// I2S receive controller: start-up sequencing, SCK/WS generation, slot
// deserialisation and a single-entry valid/ready holding register.
module i2s_rx_ctrl
    import i2s_pkg::*;
#(
    parameter int SCK_HALF_DIV  = 4,
    parameter int SAMPLE_BITS   = DEF_SAMPLE_BITS,
    parameter int SLOT_BITS     = DEF_SLOT_BITS,
    parameter int WARMUP_FRAMES = 4096
) (
    input  logic                          clk_in,
    input  logic                          reset,
    input  logic                          clk_lock,
    input  logic                          enable,
    input  logic                          sd_in,
    output logic                          sck_out,
    output logic                          ws_out,
    output logic signed [SAMPLE_BITS-1:0] sample_data,
    output logic                          sample_right,
    output logic                          sample_valid,
    input  logic                          sample_ready,
    output logic                          overflow,
    output logic                          running
);

    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam int FRM_W      = $clog2(WARMUP_FRAMES + 1);

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] SLOT_B   = BIT_W'(SLOT_BITS);
    localparam logic [BIT_W-1:0] SAMP_B   = BIT_W'(SAMPLE_BITS);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(WARMUP_FRAMES - 1);

    i2s_state_e state_r;
    i2s_state_e next_state_s;

    logic [BIT_W-1:0]       bit_cnt_r;
    logic [BIT_W-1:0]       bit_next_s;
    logic [BIT_W-1:0]       pos_s;
    logic [FRM_W-1:0]       frame_cnt_r;
    logic [SAMPLE_BITS-2:0] shift_r;
    logic [SAMPLE_BITS-1:0] cap_word_s;
    logic                   right_slot_s;
    logic                   frame_end_s;
    logic                   capture_s;
    logic                   slot_done_s;
    logic                   sck_s;
    logic                   rise_s;
    logic                   fall_s;
    logic                   ws_r;

    logic signed [SAMPLE_BITS-1:0] data_r;
    logic                          right_r;
    logic                          valid_r;
    logic                          overflow_r;
    logic                          running_r;

    // Divider is cleared in the same edge the FSM falls back to IDLE.
    i2s_sck_div #(
        .HALF_DIV (SCK_HALF_DIV)
    ) u_sck_div (
        .clk_in (clk_in),
        .reset  (reset),
        .en     (state_r != ST_IDLE),
        .clr    (next_state_s == ST_IDLE),
        .sck    (sck_s),
        .rise   (rise_s),
        .fall   (fall_s)
    );

    // Slot position, bit counter successor and slot/frame events.
    always_comb begin
        right_slot_s = (bit_cnt_r >= SLOT_B);
        if (right_slot_s) begin
            pos_s = bit_cnt_r - SLOT_B;
        end else begin
            pos_s = bit_cnt_r;
        end
        if (bit_cnt_r == BIT_LAST) begin
            bit_next_s = {BIT_W{1'b0}};
        end else begin
            bit_next_s = bit_cnt_r + BIT_W'(1'b1);
        end
        frame_end_s = fall_s && (bit_cnt_r == BIT_LAST);
        capture_s   = rise_s && (pos_s != {BIT_W{1'b0}}) && (pos_s <= SAMP_B);
        slot_done_s = rise_s && (pos_s == SAMP_B) &&
                      ((state_r == ST_RUN) || (state_r == ST_STOP));
        cap_word_s  = {shift_r, sd_in};
    end

    // Sequencer next-state logic; lock loss overrides everything.
    always_comb begin
        next_state_s = state_r;
        if (!clk_lock) begin
            next_state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (enable) next_state_s = ST_WARMUP;
                    else        next_state_s = ST_IDLE;
                end
                ST_WARMUP: begin
                    if (!enable)                                     next_state_s = ST_STOP;
                    else if (frame_end_s && (frame_cnt_r == FRM_LAST)) next_state_s = ST_RUN;
                    else                                             next_state_s = ST_WARMUP;
                end
                ST_RUN: begin
                    if (!enable) next_state_s = ST_STOP;
                    else         next_state_s = ST_RUN;
                end
                ST_STOP: begin
                    // Re-enable is only honoured at the frame boundary, skipping warm-up.
                    if (frame_end_s) next_state_s = enable ? ST_RUN : ST_IDLE;
                    else             next_state_s = ST_STOP;
                end
                default: next_state_s = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Bit/frame counters, word select and capture shift register.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            bit_cnt_r   <= {BIT_W{1'b0}};
            frame_cnt_r <= {FRM_W{1'b0}};
            ws_r        <= CH_LEFT;
            shift_r     <= {(SAMPLE_BITS-1){1'b0}};
        end else if (next_state_s == ST_IDLE) begin
            bit_cnt_r   <= {BIT_W{1'b0}};
            frame_cnt_r <= {FRM_W{1'b0}};
            ws_r        <= CH_LEFT;
            shift_r     <= {(SAMPLE_BITS-1){1'b0}};
        end else begin
            if (fall_s) begin
                bit_cnt_r <= bit_next_s;
                ws_r      <= (bit_next_s >= SLOT_B) ? CH_RIGHT : CH_LEFT;
            end
            if (frame_end_s && (state_r == ST_WARMUP)) begin
                frame_cnt_r <= frame_cnt_r + FRM_W'(1'b1);
            end
            if (capture_s) begin
                shift_r <= cap_word_s[SAMPLE_BITS-2:0];
            end
        end
    end

    // Holding register, handshake, sticky overflow and running flag.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            data_r     <= {SAMPLE_BITS{1'b0}};
            right_r    <= CH_LEFT;
            valid_r    <= 1'b0;
            overflow_r <= 1'b0;
            running_r  <= 1'b0;
        end else begin
            if (slot_done_s) begin
                if (!valid_r || sample_ready) begin
                    data_r  <= cap_word_s;
                    right_r <= right_slot_s ? CH_RIGHT : CH_LEFT;
                    valid_r <= 1'b1;
                end else begin
                    overflow_r <= 1'b1;
                end
            end else if (valid_r && sample_ready) begin
                valid_r <= 1'b0;
            end
            if ((state_r == ST_IDLE) && (next_state_s == ST_WARMUP)) begin
                overflow_r <= 1'b0;
            end
            running_r <= (next_state_s == ST_RUN);
        end
    end

    assign sck_out      = sck_s;
    assign ws_out       = ws_r;
    assign sample_data  = data_r;
    assign sample_right = right_r;
    assign sample_valid = valid_r;
    assign overflow     = overflow_r;
    assign running      = running_r;

endmodule
